// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte FIFO behind the UART receiver
// Optional build macro UART_FIFO_DROP_OLDEST_EN: overflow evicts the head and keeps the newest byte.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       ovf_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;
  logic             push;
  logic             ovf_evt;
  logic             wr_en;
  logic             rd_en;

  // Status flags come only from registered pointers, so no input reaches an output combinationally.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level     = wr_ptr - rd_ptr;
  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

  assign pop     = out_valid && out_ready;
  assign push    = in_valid && (!full || pop);
  assign ovf_evt = in_valid && full && !pop;

`ifdef UART_FIFO_DROP_OLDEST_EN
  assign wr_en = push || ovf_evt;
  assign rd_en = pop || ovf_evt;
`else
  assign wr_en = push;
  assign rd_en = pop;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // A fresh overflow in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ovf_evt) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [4:0]       level;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             ovf_clear = 1'b0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic       ovf_m = 1'b0;
  logic [7:0] last_read = '0;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("head", 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  // One clock cycle: drive inputs, update the queue model, compare popped bytes, then check state after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic c);
    logic full_m;
    logic pop_m;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    ovf_clear = c;
    #1;
    full_m = (q.size() == DEPTH);
    pop_m  = (q.size() != 0) && r;
    if (pop_m) begin
      chk("pop_valid", 32'(out_valid), 32'h1);
      chk("pop_data", 32'(out_data), 32'(q[0]));
      last_read = q.pop_front();
    end
    if (v && (!full_m || pop_m)) begin
      q.push_back(d);
      if (c) ovf_m = 1'b0;
    end else if (v) begin
      ovf_m = 1'b1;
`ifdef UART_FIFO_DROP_OLDEST_EN
      void'(q.pop_front());
      q.push_back(d);
`endif
    end else if (c) begin
      ovf_m = 1'b0;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ovf_clear = 1'b0;
    check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained", 32'(q.size()), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values while held in reset.
    #2;
    check_state();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_state();

    // Single byte with consumer stalled, then pop it.
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Fill to DEPTH, read back in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_after_fill", 32'(full), 32'h1);
    drain();
    chk("empty_out_data", 32'(out_data), 32'h0);

    // Overflow with no pop, then clear the sticky flag.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'h1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'h0);

    // Overflow and clear in the same cycle: set wins.
    cycle(1'b1, 8'hBB, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'h1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Push and pop together while full: no overflow, level stays DEPTH.
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_pushpop_ovf", 32'(overflow), 32'h0);
    chk("full_pushpop_level", 32'(level), 32'(DEPTH));
    drain();
    chk("last_read_55", 32'(last_read), 32'h55);

    // Push and ready together while empty: no bypass.
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    chk("no_bypass_valid", 32'(out_valid), 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bypass_level0", 32'(level), 32'h0);

    // Back-to-back push/pop stream.
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h11 + i), 1'b1, 1'b0);
    drain();

    // Asynchronous reset in mid-cycle.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    ovf_m = 1'b0;
    check_state();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1, 8'h7E, 1'b0, 1'b0);
    chk("head_after_reset", 32'(out_data), 32'h7E);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
